// File: rtl/datamem_ctrl.sv
// -----------------------------------------------------------------------------
// datamem_ctrl
//   Data memory controller for the MIPS datapath. Supports byte, halfword and
//   word accesses with MIPS (big-endian) lane order, sign/zero extension on
//   narrow loads, and a configurable number of wait states between accepting a
//   request and performing the storage access.
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous, active-high reset (storage is not cleared)
//     address     byte address; upper bits beyond the array wrap
//     write_data  store data, right-justified for byte/half stores
//     MemRead     load request
//     MemWrite    store request
//     size        00 byte, 01 half, 10 word, 11 reserved (rejected)
//     sign_ext    1 = sign-extend narrow loads, 0 = zero-extend
//     read_data   last completed load result (held)
//     busy        an accepted request is in progress
//     done        one-cycle pulse when an access completes
//     err         one-cycle pulse when a request is rejected
// -----------------------------------------------------------------------------
module datamem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int INIT_ZERO   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD_C = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO_C  = CW'(0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_ACCESS = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   wait_cnt_r;
  logic [AW-1:0]   idx_r;
  logic [1:0]      off_r;
  logic [31:0]     wdata_r;
  logic [1:0]      size_r;
  logic            sign_ext_r;
  logic            is_write_r;

  logic            req_s;
  logic            bad_s;
  logic            accept_s;
  logic            reject_s;
  logic            access_s;
  logic [31:0]     rd_word_s;
  logic [31:0]     load_val_s;
  logic [31:0]     store_val_s;
  logic            addr_unused_s;

  // Storage is only initialised for simulation; reset never touches it.
  logic [31:0] mem_r [DEPTH_WORDS] = '{default: (INIT_ZERO != 0) ? 32'h0000_0000 : {32{1'bx}}};

  // Address bits above the word index are ignored so accesses wrap.
  assign addr_unused_s = ^address[31:AW+2];

  // Select the addressed lane(s) of a word and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  sz,
                                               input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (sz)
      2'b00:   res = {{24{sx & b[7]}}, b};
      2'b01:   res = {{16{sx & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Merge right-justified store data into the addressed lane(s), keeping the rest.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  off,
                                              input logic [1:0]  sz);
    logic [31:0] res;
    res = word;
    case (sz)
      2'b00: begin
        case (off)
          2'b00:   res[31:24] = data[7:0];
          2'b01:   res[23:16] = data[7:0];
          2'b10:   res[15:8]  = data[7:0];
          default: res[7:0]   = data[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          res[15:0] = data[15:0];
        end else begin
          res[31:16] = data[15:0];
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

  // Classify the incoming request: conflicting direction, reserved size or misalignment.
  always_comb begin
    req_s = MemRead | MemWrite;
    case (size)
      2'b00:   bad_s = 1'b0;
      2'b01:   bad_s = address[0];
      2'b10:   bad_s = (address[1:0] != 2'b00);
      default: bad_s = 1'b1;
    endcase
    if (MemRead && MemWrite) begin
      bad_s = 1'b1;
    end else begin
      bad_s = bad_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; requests are only looked at while idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_s && !bad_s) begin
          state_nxt_s = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_cnt_r == CNT_ZERO_C) begin
          state_nxt_s = S_ACCESS;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_ACCESS: state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // FSM output decode: accept/reject strobes in IDLE, access strobe in ACCESS.
  always_comb begin
    accept_s = 1'b0;
    reject_s = 1'b0;
    access_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        accept_s = req_s & ~bad_s;
        reject_s = req_s & bad_s;
      end
      S_WAIT: begin
        access_s = 1'b0;
      end
      S_ACCESS: begin
        access_s = 1'b1;
      end
      default: begin
        access_s = 1'b0;
      end
    endcase
  end

  // Capture the request so the requester may change its inputs once accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r      <= {AW{1'b0}};
      off_r      <= 2'b00;
      wdata_r    <= 32'h0000_0000;
      size_r     <= 2'b00;
      sign_ext_r <= 1'b0;
      is_write_r <= 1'b0;
    end else if (accept_s) begin
      idx_r      <= address[AW+1:2];
      off_r      <= address[1:0];
      wdata_r    <= write_data;
      size_r     <= size;
      sign_ext_r <= sign_ext;
      is_write_r <= MemWrite;
    end
  end

  // Wait-state counter: loaded on accept, counts down to zero while in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= CNT_ZERO_C;
    end else if (accept_s) begin
      wait_cnt_r <= WAIT_LOAD_C;
    end else if ((state_r == S_WAIT) && (wait_cnt_r != CNT_ZERO_C)) begin
      wait_cnt_r <= wait_cnt_r - CNT_ONE_C;
    end
  end

  // Read-modify-write datapath for the captured access.
  always_comb begin
    rd_word_s   = mem_r[idx_r];
    load_val_s  = load_extract(rd_word_s, off_r, size_r, sign_ext_r);
    store_val_s = store_merge(rd_word_s, wdata_r, off_r, size_r);
  end

  // Storage write port; an access abandoned by reset never reaches here.
  always_ff @(posedge clk) begin
    if (access_s && is_write_r && !reset) begin
      mem_r[idx_r] <= store_val_s;
    end
  end

  // Registered handshake outputs and load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= 32'h0000_0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy <= (state_nxt_s != S_IDLE);
      done <= access_s;
      err  <= reject_s;
      if (access_s && !is_write_r) begin
        read_data <= load_val_s;
      end
    end
  end

endmodule

// File: tb/tb_datamem_ctrl.sv
module tb_datamem_ctrl;

  localparam int DEPTH = 256;
  localparam int W0    = 2;
  localparam int W1    = 0;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [31:0] a0, d0, a1, d1;
  logic        rd0, wr0, rd1, wr1, sx0, sx1;
  logic [1:0]  sz0, sz1;
  logic [31:0] q0, q1;
  logic        busy0, done0, err0, busy1, done1, err1;

  datamem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0), .INIT_ZERO(1)) dut0 (
    .clk(clk), .reset(rst0), .address(a0), .write_data(d0), .MemRead(rd0),
    .MemWrite(wr0), .size(sz0), .sign_ext(sx0), .read_data(q0), .busy(busy0),
    .done(done0), .err(err0)
  );

  datamem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1), .INIT_ZERO(1)) dut1 (
    .clk(clk), .reset(rst1), .address(a1), .write_data(d1), .MemRead(rd1),
    .MemWrite(wr1), .size(sz1), .sign_ext(sx1), .read_data(q1), .busy(busy1),
    .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  // kind: 0 load, 1 store, 2 rejected
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] mmem [2][DEPTH];
  logic [31:0] mrd [2];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 0) ? done0 : done1;
  endfunction

  function automatic logic get_err(input int w);
    return (w == 0) ? err0 : err1;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? busy0 : busy1;
  endfunction

  task automatic drive(input int w, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic sx);
    if (w == 0) begin
      rd0 = rd; wr0 = wr; a0 = a; d0 = d; sz0 = sz; sx0 = sx;
    end else begin
      rd1 = rd; wr1 = wr; a1 = a; d1 = d; sz1 = sz; sx1 = sx;
    end
  endtask

  // Scoreboard monitor: every done/err pops one expectation.
  task automatic monitor(input int w, input logic dn, input logic er, input logic [31:0] rdv);
    exp_t e;
    int   n;
    if (dn || er) begin
      check("done_err_exclusive", {31'b0, dn & er}, 32'h0);
      n = (w == 0) ? sb0.size() : sb1.size();
      if (n == 0) begin
        check("unexpected_response", 32'h1, 32'h0);
      end else begin
        if (w == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check("response_is_err", {31'b0, er}, {31'b0, e.kind == 2'd2});
        check("read_data", rdv, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0, done0, err0, q0);
    monitor(1, done1, err1, q1);
  end

  // Issue one request, update the reference model, and check handshake timing.
  task automatic issue(input int w, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic sx);
    bit          bad, seen;
    int          idx, off, sh, edges, bcyc, nerr, ndone, wt;
    logic [31:0] word, v, mask;
    exp_t        e;
    wt   = (w == 0) ? W0 : W1;
    bad  = (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00);
    idx  = int'(a[31:2]) % DEPTH;
    off  = int'(a[1:0]);
    word = mmem[w][idx];
    if (bad) begin
      e = '{kind: 2'd2, data: mrd[w]};
    end else if (wr) begin
      case (sz)
        2'b00: begin
          sh = 8 * (3 - off); mask = 32'hFF << sh;
          v = (word & ~mask) | ((d & 32'hFF) << sh);
        end
        2'b01: begin
          sh = (off == 0) ? 16 : 0; mask = 32'hFFFF << sh;
          v = (word & ~mask) | ((d & 32'hFFFF) << sh);
        end
        default: v = d;
      endcase
      mmem[w][idx] = v;
      e = '{kind: 2'd1, data: mrd[w]};
    end else begin
      case (sz)
        2'b00: begin
          v = (word >> (8 * (3 - off))) & 32'hFF;
          if (sx && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end
        2'b01: begin
          v = (word >> ((off == 0) ? 16 : 0)) & 32'hFFFF;
          if (sx && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        default: v = word;
      endcase
      mrd[w] = v;
      e = '{kind: 2'd0, data: v};
    end
    if (w == 0) sb0.push_back(e);
    else        sb1.push_back(e);

    @(negedge clk);
    drive(w, rd, wr, a, d, sz, sx);
    @(posedge clk);
    #1;
    drive(w, 1'b0, 1'b0, $urandom(), $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    nerr = 0; ndone = 0; bcyc = 0; edges = 0; seen = 0;
    if (bad) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        nerr  += int'(get_err(w));
        ndone += int'(get_done(w));
        bcyc  += int'(get_busy(w));
      end
      check("err_pulse_count", 32'(nerr), 32'd1);
      check("err_no_done", 32'(ndone), 32'd0);
      check("err_no_busy", 32'(bcyc), 32'd0);
    end else begin
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (get_done(w)) begin
          seen = 1;
          check("done_latency_edges", 32'(edges), 32'(wt + 1));
          check("busy_cycles", 32'(bcyc), 32'(wt + 1));
          check("busy_low_at_done", {31'b0, get_busy(w)}, 32'h0);
        end else begin
          bcyc += int'(get_busy(w));
          nerr += int'(get_err(w));
          @(posedge clk);
          edges++;
        end
      end
      check("done_seen_in_time", {31'b0, seen}, 32'h1);
      check("no_err_on_valid", 32'(nerr), 32'd0);
    end
  endtask

  initial begin
    int          idx, off, r;
    logic        rd, wr;
    logic [1:0]  sz;
    logic [31:0] a;

    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    mrd[0] = 32'h0;
    mrd[1] = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_busy0", {31'b0, busy0}, 32'h0);
    check("reset_done0", {31'b0, done0}, 32'h0);
    check("reset_err0", {31'b0, err0}, 32'h0);
    check("reset_rdata0", q0, 32'h0);
    check("reset_busy1", {31'b0, busy1}, 32'h0);
    check("reset_rdata1", q1, 32'h0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Known contents for the low 16 words of both memories.
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++)
        issue(w, 1'b0, 1'b1, 32'(i * 4), $urandom(), 2'b10, 1'b0);

    // Word store/load round trip.
    issue(0, 1'b0, 1'b1, 32'h4, 32'hDAFE_EDBE, 2'b10, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0);
    // Byte lane update and extension.
    issue(0, 1'b0, 1'b1, 32'h8, 32'h1234_5678, 2'b10, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h9, 32'h0000_0080, 2'b00, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h9, 32'h0, 2'b00, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h9, 32'h0, 2'b00, 1'b0);
    // Halfword lanes and extension.
    issue(0, 1'b0, 1'b1, 32'h0, 32'h0000_8001, 2'b10, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h2, 32'h0, 2'b01, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h2, 32'h0, 2'b01, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1);
    // Rejected requests, then confirm storage untouched.
    issue(0, 1'b1, 1'b0, 32'h6, 32'h0, 2'b10, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h3, 32'hFFFF_FFFF, 2'b01, 1'b0);
    issue(0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 2'b10, 1'b0);
    issue(0, 1'b1, 1'b0, 32'hC, 32'h0, 2'b11, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0);

    // Reset while a store sits in WAIT: store abandoned, outputs cleared at once.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h10, 32'hCAFE_BABE, 2'b10, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    check("busy_in_wait", {31'b0, busy0}, 32'h1);
    rst0 = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy0}, 32'h0);
    check("midrst_done", {31'b0, done0}, 32'h0);
    check("midrst_rdata", q0, 32'h0);
    @(negedge clk);
    rst0 = 1'b0;
    mrd[0] = 32'h0;
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);

    // Address wrap on both latencies.
    issue(0, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 2'b10, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    issue(1, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 2'b10, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);

    // Randomised mix over the known region, with random upper address bits.
    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 5);
      wr = (r == 0) || (r >= 5);
      if ($urandom_range(0, 7) == 0) sz = 2'b11;
      else                           sz = 2'($urandom_range(0, 2));
      idx = $urandom_range(0, 15);
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01)      off = off & 2;
        else if (sz == 2'b10) off = 0;
      end
      a = ($urandom() & 32'hFFFF_FC00) | 32'(idx << 2) | 32'(off);
      issue((n % 4 == 3) ? 1 : 0, rd, wr, a, $urandom(), sz, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
